// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, 32x32 register file, control decode, load-use
// hazard detection, beq/j resolution and the registered ID/EX bundle.
module decode_stage #(
  parameter int PC_W  = 7,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_next_in,
  input  logic            bubble_in,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rt,
  output logic            stall,
  output logic            dec,
  output logic [PC_W-1:0] pc_target,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     rs_data,
  output logic [31:0]     rt_data,
  output logic [31:0]     imm_ext,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            alu_src,
  output logic            reg_dst,
  output logic [1:0]      alu_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  // IF/ID register
  logic [31:0]     ifid_instr_q;
  logic [PC_W-1:0] ifid_pc_q;

  // ID/EX register
  ctrl_t           idex_ctrl_q;
  logic [PC_W-1:0] idex_pc_q;
  logic [31:0]     idex_rs_data_q;
  logic [31:0]     idex_rt_data_q;
  logic [31:0]     idex_imm_q;
  logic [4:0]      idex_rs_q;
  logic [4:0]      idex_rt_q;
  logic [4:0]      idex_rd_q;

  logic [31:0] rf_q [NREGS];

  logic [5:0]  op;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [31:0] imm_d;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  ctrl_t       ctrl_d;
  logic        uses_rt;
  logic        hazard;
  logic        dec_d;
  logic [PC_W-1:0] target_d;

  assign op    = ifid_instr_q[31:26];
  assign f_rs  = ifid_instr_q[25:21];
  assign f_rt  = ifid_instr_q[20:16];
  assign f_rd  = ifid_instr_q[15:11];
  assign imm_d = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

  // Written on the falling edge so a writeback is readable in the same cycle.
  always_ff @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign rs_val = (f_rs == 5'd0) ? 32'd0 : rf_q[f_rs];
  assign rt_val = (f_rt == 5'd0) ? 32'd0 : rf_q[f_rt];

  always_comb begin
    ctrl_d  = '0;
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.alu_op    = 2'b10;
        uses_rt          = 1'b1;
      end
      OP_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
      end
      OP_SW: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        uses_rt          = 1'b1;
      end
      OP_ADDI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        ctrl_d.alu_op = 2'b01;
        uses_rt       = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard = !rst && ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == f_rs) || ((ex_rt == f_rt) && uses_rt));

  // A stalled branch is not resolved; it re-evaluates once the load has moved on.
  always_comb begin
    dec_d    = 1'b0;
    target_d = '0;
    if (!rst && !hazard) begin
      if (op == OP_BEQ && rs_val == rt_val) begin
        dec_d    = 1'b1;
        target_d = ifid_pc_q + ifid_instr_q[PC_W-1:0];
      end else if (op == OP_J) begin
        dec_d    = 1'b1;
        target_d = ifid_instr_q[PC_W-1:0];
      end
    end
  end

  assign stall     = hazard;
  assign dec       = dec_d;
  assign pc_target = target_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
    end else if (hazard) begin
      ifid_instr_q <= ifid_instr_q;
      ifid_pc_q    <= ifid_pc_q;
    end else if (dec_d || bubble_in) begin
      ifid_instr_q <= '0;
      ifid_pc_q    <= pc_next_in;
    end else begin
      ifid_instr_q <= instr_in;
      ifid_pc_q    <= pc_next_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ctrl_q    <= '0;
      idex_pc_q      <= '0;
      idex_rs_data_q <= '0;
      idex_rt_data_q <= '0;
      idex_imm_q     <= '0;
      idex_rs_q      <= '0;
      idex_rt_q      <= '0;
      idex_rd_q      <= '0;
    end else begin
      idex_ctrl_q    <= hazard ? ctrl_t'('0) : ctrl_d;
      idex_pc_q      <= ifid_pc_q;
      idex_rs_data_q <= rs_val;
      idex_rt_data_q <= rt_val;
      idex_imm_q     <= imm_d;
      idex_rs_q      <= f_rs;
      idex_rt_q      <= f_rt;
      idex_rd_q      <= f_rd;
    end
  end

  assign id_pc      = idex_pc_q;
  assign rs_data    = idex_rs_data_q;
  assign rt_data    = idex_rt_data_q;
  assign imm_ext    = idex_imm_q;
  assign rs         = idex_rs_q;
  assign rt         = idex_rt_q;
  assign rd         = idex_rd_q;
  assign reg_write  = idex_ctrl_q.reg_write;
  assign mem_read   = idex_ctrl_q.mem_read;
  assign mem_write  = idex_ctrl_q.mem_write;
  assign mem_to_reg = idex_ctrl_q.mem_to_reg;
  assign alu_src    = idex_ctrl_q.alu_src;
  assign reg_dst    = idex_ctrl_q.reg_dst;
  assign alu_op     = idex_ctrl_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios then random traffic,
// compared against a cycle-level reference model of the decode stage.
module tb_decode_stage;

  localparam int PC_W = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     instr_in;
  logic [PC_W-1:0] pc_next_in;
  logic            bubble_in;
  logic            wb_we;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            ex_mem_read;
  logic [4:0]      ex_rt;
  logic            stall;
  logic            dec;
  logic [PC_W-1:0] pc_target;
  logic [PC_W-1:0] id_pc;
  logic [31:0]     rs_data;
  logic [31:0]     rt_data;
  logic [31:0]     imm_ext;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            mem_to_reg;
  logic            alu_src;
  logic            reg_dst;
  logic [1:0]      alu_op;

  decode_stage #(.PC_W(PC_W), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_next_in(pc_next_in),
    .bubble_in(bubble_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .stall(stall), .dec(dec),
    .pc_target(pc_target), .id_pc(id_pc), .rs_data(rs_data), .rt_data(rt_data),
    .imm_ext(imm_ext), .rs(rs), .rt(rt), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .reg_dst(reg_dst), .alu_op(alu_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            stall;
    logic            dec;
    logic [PC_W-1:0] tgt;
  } comb_t;

  typedef struct {
    bit              ctrl_only;
    logic [7:0]      ctrl;
    logic [PC_W-1:0] pc;
    logic [31:0]     rsd;
    logic [31:0]     rtd;
    logic [31:0]     imm;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
  } idex_t;

  comb_t comb_q[$];
  idex_t idex_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_rf [32];
  logic [31:0] m_instr;
  int          m_pc;

  // Controls per opcode as {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,alu_op}
  function automatic logic [7:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'd0:  return 8'b1000_0110;
      6'd35: return 8'b1101_1000;
      6'd43: return 8'b0010_1000;
      6'd8:  return 8'b1000_1000;
      6'd4:  return 8'b0000_0001;
      default: return 8'b0;
    endcase
  endfunction

  function automatic logic [31:0] r_ins(input int s, input int t, input int d);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int s, input int t, input int imm);
    return {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_ins(input int tgt);
    return {6'd2, 26'(tgt)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input logic [31:0] ins, input logic [PC_W-1:0] pcn,
                      input bit bub, input bit we, input logic [4:0] wa,
                      input logic [31:0] wd, input bit emr, input logic [4:0] ert);
    comb_t c;
    idex_t e;
    logic [5:0] op;
    logic [4:0] fs, ft;
    logic [31:0] sv, tv;
    bit st;
    @(posedge clk);
    #2;
    rst = r; instr_in = ins; pc_next_in = pcn; bubble_in = bub;
    wb_we = we; wb_addr = wa; wb_data = wd; ex_mem_read = emr; ex_rt = ert;
    c = '{stall: 1'b0, dec: 1'b0, tgt: '0};
    e = '{ctrl_only: 1'b0, ctrl: '0, pc: '0, rsd: '0, rtd: '0, imm: '0,
          rs: '0, rt: '0, rd: '0};
    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_instr = '0;
      m_pc    = 0;
    end else begin
      if (we && wa != 0) m_rf[wa] = wd;
      op = m_instr[31:26];
      fs = m_instr[25:21];
      ft = m_instr[20:16];
      sv = (fs == 0) ? 32'd0 : m_rf[fs];
      tv = (ft == 0) ? 32'd0 : m_rf[ft];
      st = emr && ert != 0 &&
           (ert == fs || (ert == ft && (op == 6'd0 || op == 6'd43 || op == 6'd4)));
      c.stall = st;
      if (!st) begin
        if (op == 6'd4 && sv == tv) begin
          c.dec = 1'b1;
          c.tgt = PC_W'((m_pc + int'(m_instr[6:0])) % (1 << PC_W));
        end else if (op == 6'd2) begin
          c.dec = 1'b1;
          c.tgt = m_instr[PC_W-1:0];
        end
      end
      e.ctrl_only = st;
      e.ctrl = st ? 8'd0 : ctrl_of(op);
      e.pc   = PC_W'(m_pc);
      e.rsd  = sv;
      e.rtd  = tv;
      e.imm  = {{16{m_instr[15]}}, m_instr[15:0]};
      e.rs   = fs;
      e.rt   = ft;
      e.rd   = m_instr[15:11];
      if (!st) begin
        m_instr = (c.dec || bub) ? 32'd0 : ins;
        m_pc    = int'(pcn);
      end
    end
    comb_q.push_back(c);
    idex_q.push_back(e);
  endtask

  // Monitor: ID/EX sampled just after the rising edge, combinational
  // outputs sampled after the falling-edge register write.
  initial begin
    comb_t c;
    idex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (idex_q.size() > 0) begin
        e = idex_q.pop_front();
        check("ctrl", {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op}, e.ctrl);
        if (!e.ctrl_only) begin
          check("id_pc", id_pc, e.pc);
          check("rs_data", rs_data, e.rsd);
          check("rt_data", rt_data, e.rtd);
          check("imm_ext", imm_ext, e.imm);
          check("rs", rs, e.rs);
          check("rt", rt, e.rt);
          check("rd", rd, e.rd);
        end
        $display("[TB] idex t=%0t ctrl=%b pc=%h rs_data=%h", $time, e.ctrl, e.pc, e.rsd);
      end
      #5;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        check("stall", stall, c.stall);
        check("dec", dec, c.dec);
        check("pc_target", pc_target, c.tgt);
      end
    end
  end

  function automatic logic [31:0] rand_ins();
    int sel = $urandom_range(0, 6);
    int s = $urandom_range(0, 7);
    int t = $urandom_range(0, 7);
    int d = $urandom_range(0, 31);
    int imm = $urandom_range(0, 65535);
    case (sel)
      0: return r_ins(s, t, d);
      1: return i_ins(35, s, t, imm);
      2: return i_ins(43, s, t, imm);
      3: return i_ins(8, s, t, imm);
      4: return i_ins(4, s, t, imm);
      5: return j_ins(int'($urandom_range(0, 1 << 20)));
      default: return i_ins(int'($urandom_range(9, 63)), s, t, imm);
    endcase
  endfunction

  localparam logic [31:0] LW  = 32'h8C010004;
  localparam logic [31:0] NOP = 32'h0;

  initial begin
    logic [31:0] sw_w, addi_w;
    sw_w   = i_ins(43, 1, 2, 8);
    addi_w = i_ins(8, 3, 3, 1);
    rst = 1'b1; instr_in = LW; pc_next_in = '0; bubble_in = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_mem_read = 1'b0; ex_rt = '0;

    // Reset, then the lw reaches ID/EX two edges after release
    step(1, LW, 7'd0, 0, 0, 0, 0, 0, 0);
    step(1, LW, 7'd0, 0, 0, 0, 0, 0, 0);
    step(0, LW, 7'd1, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'd2, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'd3, 0, 0, 0, 0, 0, 0);
    // Writeback bypass and $0 write discard
    step(0, r_ins(3, 0, 5), 7'd4, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'd5, 0, 1, 5'd3, 32'hDEADBEEF, 0, 0);
    step(0, NOP, 7'd6, 0, 0, 0, 0, 0, 0);
    step(0, r_ins(0, 0, 6), 7'd7, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'd8, 0, 1, 5'd0, 32'h1234, 0, 0);
    step(0, NOP, 7'd9, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'd10, 0, 1, 5'd1, 32'd7, 0, 0);
    step(0, NOP, 7'd11, 0, 1, 5'd2, 32'd7, 0, 0);
    // Load-use: one stall cycle, then the add issues
    step(0, r_ins(2, 1, 4), 7'd12, 0, 0, 0, 0, 0, 0);
    step(0, sw_w, 7'd13, 0, 0, 0, 0, 1, 5'd2);
    step(0, sw_w, 7'd13, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'd14, 0, 0, 0, 0, 0, 0);
    // beq taken, normal and wrapping target
    step(0, i_ins(4, 1, 2, 5), 7'h10, 0, 0, 0, 0, 0, 0);
    step(0, addi_w, 7'h11, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'h12, 0, 0, 0, 0, 0, 0);
    step(0, i_ins(4, 1, 2, 16'h7F), 7'h10, 0, 0, 0, 0, 0, 0);
    step(0, addi_w, 7'h11, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'h12, 0, 0, 0, 0, 0, 0);
    // Jump, then a bubbled fetch word
    step(0, j_ins(26'h2A), 7'd20, 0, 0, 0, 0, 0, 0);
    step(0, addi_w, 7'd21, 0, 0, 0, 0, 0, 0);
    step(0, addi_w, 7'd22, 1, 0, 0, 0, 0, 0);
    step(0, NOP, 7'd23, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'd24, 0, 0, 0, 0, 0, 0);
    // Stall wins over a taken beq; branch resolves the next cycle
    step(0, i_ins(4, 2, 1, 3), 7'h30, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'h31, 0, 0, 0, 0, 1, 5'd2);
    step(0, NOP, 7'h31, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 7'h32, 0, 0, 0, 0, 0, 0);

    // Random traffic with occasional mid-stream resets
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 59) == 0, rand_ins(), PC_W'($urandom_range(0, 127)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)));
    end
    for (int k = 0; k < 3; k++) step(0, NOP, 7'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #8;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
